// File: rtl/spike_counter_bank.sv
// ---------------------------------------------------------------------------
// spike_counter_bank
//   Multi-channel spike-event counter bank for the neuron accumulate path.
//   Every channel counts its own events up or down and either clamps or wraps
//   at the range limits. A sticky flag records any overflow or underflow.
//   A two-state snapshot engine captures all channels in a single cycle and
//   presents the result through a valid/ready handshake. The live counters
//   can optionally restart when a snapshot is captured.
//
// Parameters
//   SIZE_CODE      width of each channel counter (>= 2)
//   NUM_CH         number of independent channels (>= 1)
//   SATURATE       1 = clamp at the limits, 0 = wrap modulo 2^SIZE_CODE
//   CLEAR_ON_SNAP  1 = a snapshot capture restarts the live counters
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   enable      in   global count enable
//   bitin       in   [NUM_CH]  per-channel spike event
//   dir         in   [NUM_CH]  per-channel direction (0 = up, 1 = down)
//   clear       in   synchronous clear of counters and overflow flags
//   snap_req    in   request a coherent snapshot
//   snap_ready  in   consumer accepts snap_data
//   snap_valid  out  snap_data holds a captured snapshot
//   snap_data   out  [NUM_CH*SIZE_CODE]  captured counts, channel c at [c*SIZE_CODE +: SIZE_CODE]
//   counter     out  [NUM_CH*SIZE_CODE]  live counts, same packing
//   ovf         out  [NUM_CH]  sticky overflow/underflow flags
// ---------------------------------------------------------------------------
module spike_counter_bank #(
    parameter int SIZE_CODE     = 8,
    parameter int NUM_CH        = 4,
    parameter int SATURATE      = 1,
    parameter int CLEAR_ON_SNAP = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             bitin,
    input  logic [NUM_CH-1:0]             dir,
    input  logic                          clear,
    input  logic                          snap_req,
    input  logic                          snap_ready,
    output logic                          snap_valid,
    output logic [NUM_CH*SIZE_CODE-1:0]   snap_data,
    output logic [NUM_CH*SIZE_CODE-1:0]   counter,
    output logic [NUM_CH-1:0]             ovf
);

    localparam logic [SIZE_CODE-1:0] CNT_MAX  = '1;
    localparam logic [SIZE_CODE-1:0] CNT_ZERO = '0;
    localparam logic [SIZE_CODE-1:0] CNT_ONE  = {{(SIZE_CODE-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                               r_state;
    logic [NUM_CH-1:0][SIZE_CODE-1:0]     r_cnt;
    logic [NUM_CH-1:0]                    r_ovf;
    logic [NUM_CH*SIZE_CODE-1:0]          r_snap_data;
    logic                                 r_snap_valid;

    logic                                 w_capture;
    logic                                 w_restart;
    logic [NUM_CH-1:0][SIZE_CODE-1:0]     w_cnt_nxt;
    logic [NUM_CH-1:0]                    w_ovf_set;

    // One counting step from 'base'. Result MSB flags a limit hit; the low
    // bits are the next count, clamped or wrapped according to SATURATE.
    function automatic logic [SIZE_CODE:0] step_count(
        input logic [SIZE_CODE-1:0] base,
        input logic                 ev,
        input logic                 down
    );
        logic [SIZE_CODE:0] res;
        res = {1'b0, base};
        if (ev) begin
            if (!down) begin
                if (base == CNT_MAX)
                    res = {1'b1, (SATURATE != 0) ? CNT_MAX : CNT_ZERO};
                else
                    res = {1'b0, base + CNT_ONE};
            end else begin
                if (base == CNT_ZERO)
                    res = {1'b1, (SATURATE != 0) ? CNT_ZERO : CNT_MAX};
                else
                    res = {1'b0, base - CNT_ONE};
            end
        end
        return res;
    endfunction

    // A capture can only start from IDLE; requests seen in HOLD, including
    // the HOLD->IDLE exit cycle, are dropped.
    assign w_capture = (r_state == IDLE) && snap_req;

    // Clear-on-snap restarts from zero but still applies this cycle's event,
    // so an event coinciding with the capture is never lost.
    assign w_restart = w_capture && (CLEAR_ON_SNAP != 0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            {w_ovf_set[c], w_cnt_nxt[c]} =
                step_count(w_restart ? CNT_ZERO : r_cnt[c], enable & bitin[c], dir[c]);
        end
    end

    // Live counters and sticky flags; clear outranks events and clear-on-snap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (clear) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_ovf_set;
        end
    end

    // Snapshot engine: captures the pre-edge counts, so same-cycle events
    // show up only in the live counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_snap_data  <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (snap_req) begin
                        r_snap_data  <= r_cnt;
                        r_snap_valid <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (snap_ready) begin
                        r_snap_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_snap_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign counter    = r_cnt;
    assign ovf        = r_ovf;
    assign snap_data  = r_snap_data;
    assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_spike_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_spike_counter_bank
//   Directed bench for spike_counter_bank. Two instances:
//     dut_a : SATURATE=1, CLEAR_ON_SNAP=0
//     dut_b : SATURATE=0, CLEAR_ON_SNAP=1
//   Each check uses hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_spike_counter_bank;

    localparam int SIZE_CODE = 8;
    localparam int NUM_CH    = 4;
    localparam int DW        = SIZE_CODE * NUM_CH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic              a_reset, a_enable, a_clear, a_snap_req, a_snap_ready;
    logic [NUM_CH-1:0] a_bitin, a_dir, a_ovf;
    logic              a_snap_valid;
    logic [DW-1:0]     a_snap_data, a_counter;

    // Instance B signals
    logic              b_reset, b_enable, b_clear, b_snap_req, b_snap_ready;
    logic [NUM_CH-1:0] b_bitin, b_dir, b_ovf;
    logic              b_snap_valid;
    logic [DW-1:0]     b_snap_data, b_counter;

    int checks = 0;
    int errors = 0;

    spike_counter_bank #(
        .SIZE_CODE(SIZE_CODE), .NUM_CH(NUM_CH), .SATURATE(1), .CLEAR_ON_SNAP(0)
    ) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .bitin(a_bitin), .dir(a_dir),
        .clear(a_clear), .snap_req(a_snap_req), .snap_ready(a_snap_ready),
        .snap_valid(a_snap_valid), .snap_data(a_snap_data), .counter(a_counter), .ovf(a_ovf)
    );

    spike_counter_bank #(
        .SIZE_CODE(SIZE_CODE), .NUM_CH(NUM_CH), .SATURATE(0), .CLEAR_ON_SNAP(1)
    ) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .bitin(b_bitin), .dir(b_dir),
        .clear(b_clear), .snap_req(b_snap_req), .snap_ready(b_snap_ready),
        .snap_valid(b_snap_valid), .snap_data(b_snap_data), .counter(b_counter), .ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        a_reset = 1'b0; a_enable = 1'b0; a_bitin = '0; a_dir = '0;
        a_clear = 1'b0; a_snap_req = 1'b0; a_snap_ready = 1'b0;
        b_reset = 1'b0; b_enable = 1'b0; b_bitin = '0; b_dir = '0;
        b_clear = 1'b0; b_snap_req = 1'b0; b_snap_ready = 1'b0;

        // ---------------- Instance A: saturating, no clear-on-snap ----------
        tick(2);
        check("a_rst_counter", a_counter, 32'h0);
        check("a_rst_ovf", DW'(a_ovf), 32'h0);
        check("a_rst_valid", DW'(a_snap_valid), 32'h0);
        check("a_rst_snap_data", a_snap_data, 32'h0);
        a_reset = 1'b1;
        tick(1);

        // Up-count ch0 five times
        a_enable = 1'b1; a_bitin = 4'b0001; a_dir = 4'b0000;
        tick(5);
        check("a_upcount_counter", a_counter, 32'h0000_0005);
        check("a_upcount_ovf", DW'(a_ovf), 32'h0);

        // Events without enable are ignored
        a_enable = 1'b0; a_bitin = 4'b1111;
        tick(2);
        check("a_enable_low_hold", a_counter, 32'h0000_0005);

        // Saturate ch1 upward with 260 events
        a_enable = 1'b1; a_bitin = 4'b0010; a_dir = 4'b0000;
        tick(260);
        check("a_sat_up_counter", a_counter, 32'h0000_FF05);
        check("a_sat_up_ovf", DW'(a_ovf), 32'h2);

        // Count ch1 down three times; flag stays set
        a_dir = 4'b0010;
        tick(3);
        check("a_down_counter", a_counter, 32'h0000_FC05);
        check("a_down_ovf_sticky", DW'(a_ovf), 32'h2);

        // Saturating underflow on ch3 (at 0): holds 0, sets ovf[3]
        a_bitin = 4'b1000; a_dir = 4'b1000;
        tick(1);
        check("a_sat_down_counter", a_counter, 32'h0000_FC05);
        check("a_sat_down_ovf", DW'(a_ovf), 32'hA);

        // Clear wins over same-cycle events
        a_clear = 1'b1; a_bitin = 4'b0010; a_dir = 4'b0000;
        tick(1);
        a_clear = 1'b0;
        check("a_clear_counter", a_counter, 32'h0);
        check("a_clear_ovf", DW'(a_ovf), 32'h0);

        // Build {ch3..ch0} = {9,0,0,5}
        a_bitin = 4'b1001;
        tick(5);
        a_bitin = 4'b1000;
        tick(4);
        check("a_pre_snap_counter", a_counter, 32'h0900_0005);

        // Capture with same-cycle events on ch0 and ch3
        a_bitin = 4'b1001; a_snap_req = 1'b1;
        tick(1);
        a_snap_req = 1'b0;
        check("a_snap_valid_set", DW'(a_snap_valid), 32'h1);
        check("a_snap_data_capture", a_snap_data, 32'h0900_0005);
        check("a_snap_live_counter", a_counter, 32'h0A00_0006);

        // Hold for four cycles; a request in HOLD must not recapture
        tick(1);
        a_snap_req = 1'b1;
        tick(2);
        a_snap_req = 1'b0;
        tick(1);
        check("a_hold_valid", DW'(a_snap_valid), 32'h1);
        check("a_hold_snap_data", a_snap_data, 32'h0900_0005);
        check("a_hold_live_counter", a_counter, 32'h0E00_000A);

        // Release; a request in the exit cycle is dropped
        a_bitin = 4'b0000; a_snap_ready = 1'b1; a_snap_req = 1'b1;
        tick(1);
        a_snap_ready = 1'b0; a_snap_req = 1'b0;
        check("a_release_valid", DW'(a_snap_valid), 32'h0);
        check("a_release_counter", a_counter, 32'h0E00_000A);
        tick(1);
        check("a_exit_req_dropped", DW'(a_snap_valid), 32'h0);
        check("a_snap_data_kept", a_snap_data, 32'h0900_0005);

        // New capture, no clear-on-snap in this instance
        a_snap_req = 1'b1;
        tick(1);
        a_snap_req = 1'b0;
        check("a_recapture_data", a_snap_data, 32'h0E00_000A);
        check("a_recapture_live", a_counter, 32'h0E00_000A);

        // Asynchronous reset in HOLD, sampled between edges
        a_reset = 1'b0;
        #2;
        check("a_async_rst_valid", DW'(a_snap_valid), 32'h0);
        check("a_async_rst_counter", a_counter, 32'h0);
        check("a_async_rst_snap_data", a_snap_data, 32'h0);
        tick(1);
        a_reset = 1'b1; a_enable = 1'b0;
        tick(1);
        check("a_post_rst_valid", DW'(a_snap_valid), 32'h0);

        // ---------------- Instance B: wrapping, clear-on-snap ---------------
        b_reset = 1'b1;
        tick(1);
        check("b_rst_counter", b_counter, 32'h0);

        // ch2 down from 0 wraps to 255
        b_enable = 1'b1; b_bitin = 4'b0100; b_dir = 4'b0100;
        tick(1);
        check("b_wrap_down_counter", b_counter, 32'h00FF_0000);
        check("b_wrap_down_ovf", DW'(b_ovf), 32'h4);

        // ch2 up from 255 wraps to 0
        b_dir = 4'b0000;
        tick(1);
        check("b_wrap_up_counter", b_counter, 32'h0);
        check("b_wrap_up_ovf", DW'(b_ovf), 32'h4);

        // Back to 255, then clear with a same-cycle event
        b_dir = 4'b0100;
        tick(1);
        b_clear = 1'b1;
        tick(1);
        b_clear = 1'b0;
        check("b_clear_counter", b_counter, 32'h0);
        check("b_clear_ovf", DW'(b_ovf), 32'h0);

        // ch0 = 7, ch1 = 3
        b_dir = 4'b0000; b_bitin = 4'b0011;
        tick(3);
        b_bitin = 4'b0001;
        tick(4);
        check("b_pre_snap_counter", b_counter, 32'h0000_0307);

        // Capture: ch0 up event -> 1, ch1 down event from restart -> 255 + ovf
        b_snap_req = 1'b1; b_bitin = 4'b0011; b_dir = 4'b0010;
        tick(1);
        b_snap_req = 1'b0;
        check("b_cos_snap_data", b_snap_data, 32'h0000_0307);
        check("b_cos_live_counter", b_counter, 32'h0000_FF01);
        check("b_cos_ovf", DW'(b_ovf), 32'h2);
        check("b_cos_valid", DW'(b_snap_valid), 32'h1);

        // Request in HOLD neither recaptures nor restarts
        b_snap_req = 1'b1; b_bitin = 4'b0001; b_dir = 4'b0000;
        tick(1);
        b_snap_req = 1'b0;
        check("b_hold_counter", b_counter, 32'h0000_FF02);
        check("b_hold_snap_data", b_snap_data, 32'h0000_0307);
        check("b_hold_ovf_kept", DW'(b_ovf), 32'h2);

        // Release
        b_snap_ready = 1'b1; b_bitin = 4'b0000;
        tick(1);
        b_snap_ready = 1'b0;
        check("b_release_valid", DW'(b_snap_valid), 32'h0);

        // Clear outranks clear-on-snap; capture itself still happens
        b_clear = 1'b1; b_snap_req = 1'b1; b_bitin = 4'b0001;
        tick(1);
        b_clear = 1'b0; b_snap_req = 1'b0; b_bitin = 4'b0000;
        check("b_clr_prio_counter", b_counter, 32'h0);
        check("b_clr_prio_ovf", DW'(b_ovf), 32'h0);
        check("b_clr_prio_snap_data", b_snap_data, 32'h0000_FF02);
        check("b_clr_prio_valid", DW'(b_snap_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
